// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 4;

  // Which requester owns the access currently in the memory pipeline.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I_RD = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: D over I, with a saturating starvation guard that forces one I win.
module mem_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_i;

  // A limit of zero disables the guard entirely.
  assign w_force_i = (STARVE_LIMIT != 0) && i_valid &&
                     (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  assign grant_d = !rst && d_valid && !w_force_i;
  assign grant_i = !rst && i_valid && !grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!i_valid || grant_i) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (I) and load/store (D) requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [XLEN-1:0]   i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [XLEN-1:0]   i_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_wen,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [MASK_W-1:0] d_req_mask,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [XLEN-1:0]   mem_rdata
);

  logic            w_grant_i;
  logic            w_grant_d;
  owner_e          w_owner_nxt;
  owner_e          r_owner;
  logic [XLEN-1:0] r_i_hold;
  logic [XLEN-1:0] r_d_hold;
  logic            w_unused;

  // Byte-offset and aliased upper address bits carry no meaning for the memory.
  assign w_unused = ^{i_req_addr[XLEN-1:ADDR_W+2], i_req_addr[1:0],
                      d_req_addr[XLEN-1:ADDR_W+2], d_req_addr[1:0]};

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .grant_i (w_grant_i),
    .grant_d (w_grant_d)
  );

  assign i_req_ready = w_grant_i;
  assign d_req_ready = w_grant_d;

  // Memory strobes and next owner follow the same-cycle grant.
  always_comb begin
    mem_addr    = i_req_addr[ADDR_W+1:2];
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_wdata   = '0;
    mem_mask    = '0;
    w_owner_nxt = OWN_NONE;
    if (w_grant_d) begin
      mem_addr = d_req_addr[ADDR_W+1:2];
      if (d_req_wen) begin
        mem_wen     = 1'b1;
        mem_wdata   = d_req_wdata;
        mem_mask    = d_req_mask;
        w_owner_nxt = OWN_D_WR;
      end else begin
        mem_ren     = 1'b1;
        w_owner_nxt = OWN_D_RD;
      end
    end else if (w_grant_i) begin
      mem_ren     = 1'b1;
      w_owner_nxt = OWN_I_RD;
    end
  end

  // Owner tracks the access whose data arrives next cycle; holds keep the last delivered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= OWN_NONE;
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      if (r_owner == OWN_I_RD) begin
        r_i_hold <= mem_rdata;
      end
      if (r_owner == OWN_D_RD) begin
        r_d_hold <= mem_rdata;
      end else if (r_owner == OWN_D_WR) begin
        r_d_hold <= '0;
      end
    end
  end

  assign i_rsp_valid = (r_owner == OWN_I_RD);
  assign d_rsp_valid = (r_owner == OWN_D_RD) || (r_owner == OWN_D_WR);
  assign i_rsp_data  = i_rsp_valid ? mem_rdata : r_i_hold;

  always_comb begin
    d_rsp_data = r_d_hold;
    if (r_owner == OWN_D_RD) begin
      d_rsp_data = mem_rdata;
    end else if (r_owner == OWN_D_WR) begin
      d_rsp_data = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, random traffic vs a transaction model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 10;
  localparam int          LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill;
  logic        i_req_valid, d_req_valid, d_req_wen;
  logic [31:0] i_req_addr, d_req_addr, d_req_wdata;
  logic [3:0]  d_req_mask;

  logic          i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid, mem_ren, mem_wen;
  logic [31:0]   i_rsp_data, d_rsp_data, mem_wdata, rd_a;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_mask;

  logic          z_i_req_ready, z_i_rsp_valid, z_d_req_ready, z_d_rsp_valid, z_mem_ren, z_mem_wen;
  logic [31:0]   z_i_rsp_data, z_d_rsp_data, z_mem_wdata, rd_z;
  logic [AW-1:0] z_mem_addr;
  logic [3:0]    z_mem_mask;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_z [1024];

  int nvec = 0;
  int nmis = 0;

  // Transaction-level reference state
  logic [31:0] gold [1024];
  int          m_starve;
  logic        m_pi, m_pd, last_gi, last_gd;
  logic [31:0] m_pi_data, m_pd_data, m_hi, m_hd;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_mask(d_req_mask), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(rd_a)
  );

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(0)) dut_z (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(z_i_req_ready),
    .i_rsp_valid(z_i_rsp_valid), .i_rsp_data(z_i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_mask(d_req_mask), .d_req_ready(z_d_req_ready),
    .d_rsp_valid(z_d_rsp_valid), .d_rsp_data(z_d_rsp_data),
    .mem_addr(z_mem_addr), .mem_ren(z_mem_ren), .mem_wen(z_mem_wen),
    .mem_wdata(z_mem_wdata), .mem_mask(z_mem_mask), .mem_rdata(rd_z)
  );

  function automatic logic [31:0] init_word(input int k);
    return (k == 8) ? 32'h1122_3344 : (32'hC0DE_0000 | 32'(k));
  endfunction

  // Behavioural single-port memories: registered read, byte-masked write.
  always @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < 1024; k++) mem_a[k] <= init_word(k);
    end else begin
      if (mem_wen)
        for (int b = 0; b < 4; b++) if (mem_mask[b]) mem_a[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_ren) rd_a <= mem_a[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < 1024; k++) mem_z[k] <= init_word(k);
    end else begin
      if (z_mem_wen)
        for (int b = 0; b < 4; b++) if (z_mem_mask[b]) mem_z[z_mem_addr][8*b +: 8] <= z_mem_wdata[8*b +: 8];
      if (z_mem_ren) rd_z <= mem_z[z_mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] dm);
    i_req_valid = iv; i_req_addr = ia;
    d_req_valid = dv; d_req_wen = dw; d_req_addr = da; d_req_wdata = dd; d_req_mask = dm;
  endtask

  // Called mid-cycle: checks the DUT against the reference, then advances the reference.
  task automatic model_cycle();
    logic gi, gd;
    int   w;
    if (rst) begin
      chk("rst_i_ready", 32'(i_req_ready), 32'd0);
      chk("rst_d_ready", 32'(d_req_ready), 32'd0);
      chk("rst_strobes", 32'({mem_ren, mem_wen}), 32'd0);
      chk("rst_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
      chk("rst_i_rsp_data", i_rsp_data, 32'd0);
      chk("rst_d_rsp_data", d_rsp_data, 32'd0);
      chk("rst_z_ready", 32'({z_i_req_ready, z_d_req_ready}), 32'd0);
      m_starve = 0; m_pi = 1'b0; m_pd = 1'b0; m_hi = '0; m_hd = '0;
      last_gi = 1'b0; last_gd = 1'b0;
      return;
    end
    gd = d_req_valid && !((LIM != 0) && (m_starve >= LIM) && i_req_valid);
    gi = i_req_valid && !gd;
    w  = int'(d_req_addr[11:2]);
    chk("i_ready", 32'(i_req_ready), 32'(gi));
    chk("d_ready", 32'(d_req_ready), 32'(gd));
    chk("mem_ren", 32'(mem_ren), 32'(gi || (gd && !d_req_wen)));
    chk("mem_wen", 32'(mem_wen), 32'(gd && d_req_wen));
    if (gd) chk("mem_addr_d", 32'(mem_addr), 32'(d_req_addr[11:2]));
    if (gi) chk("mem_addr_i", 32'(mem_addr), 32'(i_req_addr[11:2]));
    if (gd && d_req_wen) begin
      chk("mem_wdata", mem_wdata, d_req_wdata);
      chk("mem_mask", 32'(mem_mask), 32'(d_req_mask));
    end
    chk("i_rsp_valid", 32'(i_rsp_valid), 32'(m_pi));
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(m_pd));
    chk("i_rsp_data", i_rsp_data, m_pi ? m_pi_data : m_hi);
    chk("d_rsp_data", d_rsp_data, m_pd ? m_pd_data : m_hd);
    chk("z_d_ready", 32'(z_d_req_ready), 32'(d_req_valid));
    chk("z_i_ready", 32'(z_i_req_ready), 32'(i_req_valid && !d_req_valid));
    if (m_pi) m_hi = m_pi_data;
    if (m_pd) m_hd = m_pd_data;
    m_pi = gi;
    m_pd = gd;
    if (gi) m_pi_data = gold[int'(i_req_addr[11:2])];
    if (gd) m_pd_data = d_req_wen ? 32'd0 : gold[w];
    if (gd && d_req_wen)
      for (int b = 0; b < 4; b++) if (d_req_mask[b]) gold[w][8*b +: 8] = d_req_wdata[8*b +: 8];
    m_starve = (i_req_valid && !gi) ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
    last_gi = gi;
    last_gd = gd;
  endtask

  task automatic settle();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  dm;
    logic        ir, dr, ren, wen, has_addr;
    logic [9:0]  addr;
  } vec_t;

  vec_t        tbl [11];
  logic [5:0]  pat;

  initial begin
    for (int k = 0; k < 1024; k++) gold[k] = init_word(k);
    m_starve = 0; m_pi = 1'b0; m_pd = 1'b0; m_hi = '0; m_hd = '0; m_pi_data = '0; m_pd_data = '0;
    last_gi = 1'b0; last_gd = 1'b0;

    //        iv  ia             dv  dw  da            dd             dm     ir dr ren wen has addr
    tbl[0]  = '{1, 32'h10,       0,  0, 32'h0,       32'h0,         4'h0,  1, 0, 1, 0, 1, 10'h004};
    tbl[1]  = '{0, 32'h0,        1,  0, 32'h44,      32'h0,         4'h0,  0, 1, 1, 0, 1, 10'h011};
    tbl[2]  = '{0, 32'h0,        1,  1, 32'h30,      32'h1234_5678, 4'hF,  0, 1, 0, 1, 1, 10'h00C};
    tbl[3]  = '{0, 32'h0,        0,  0, 32'h0,       32'h0,         4'h0,  0, 0, 0, 0, 0, 10'h000};
    tbl[4]  = '{1, 32'h100,      1,  0, 32'h200,     32'h0,         4'h0,  0, 1, 1, 0, 1, 10'h080};
    tbl[5]  = '{1, 32'h100,      1,  1, 32'h204,     32'hFFFF_FFFF, 4'h0,  0, 1, 0, 1, 1, 10'h081};
    tbl[6]  = '{1, 32'h100,      1,  0, 32'h208,     32'h0,         4'h0,  0, 1, 1, 0, 1, 10'h082};
    tbl[7]  = '{1, 32'h100,      1,  0, 32'h20C,     32'h0,         4'h0,  0, 1, 1, 0, 1, 10'h083};
    tbl[8]  = '{1, 32'h100,      1,  0, 32'h210,     32'h0,         4'h0,  1, 0, 1, 0, 1, 10'h040};
    tbl[9]  = '{0, 32'h0,        1,  0, 32'h210,     32'h0,         4'h0,  0, 1, 1, 0, 1, 10'h084};
    tbl[10] = '{1, 32'hFFFF_F014, 0, 0, 32'h0,       32'h0,         4'h0,  1, 0, 1, 0, 1, 10'h005};

    rst = 1'b1;
    fill = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    adv();
    fill = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0, '0);
    settle();
    adv();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("idle_ready", 32'({i_req_ready, d_req_ready}), 32'd0);
      chk("idle_strobe", 32'({mem_ren, mem_wen}), 32'd0);
      chk("idle_rsp", {i_rsp_data[30:0] | d_rsp_data[30:0], i_rsp_valid | d_rsp_valid}, 32'd0);
      adv();
    end

    // Single-cycle grant/strobe vectors
    for (int v = 0; v < 11; v++) begin
      drive(tbl[v].iv, tbl[v].ia, tbl[v].dv, tbl[v].dw, tbl[v].da, tbl[v].dd, tbl[v].dm);
      settle();
      chk($sformatf("tbl%0d_ready", v), 32'({i_req_ready, d_req_ready}), 32'({tbl[v].ir, tbl[v].dr}));
      chk($sformatf("tbl%0d_strobe", v), 32'({mem_ren, mem_wen}), 32'({tbl[v].ren, tbl[v].wen}));
      if (tbl[v].has_addr) chk($sformatf("tbl%0d_addr", v), 32'(mem_addr), 32'(tbl[v].addr));
      adv();
    end

    // Fetch: response data one cycle after grant
    drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("fetch_ready", 32'(i_req_ready), 32'd1);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("fetch_rsp_valid", 32'(i_rsp_valid), 32'd1);
    chk("fetch_rsp_data", i_rsp_data, 32'hC0DE_0004);
    adv();

    // Partial store then immediate load of the same word
    drive(1'b0, '0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
    settle();
    chk("st_ready", 32'({d_req_ready, mem_wen, mem_ren}), 32'b110);
    adv();
    drive(1'b0, '0, 1'b1, 1'b0, 32'h20, '0, '0);
    settle();
    chk("st_ack", {d_rsp_data[30:0], d_rsp_valid}, 32'd1);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("ld_after_st_valid", 32'(d_rsp_valid), 32'd1);
    chk("ld_after_st_data", d_rsp_data, 32'h1122_BEEF);
    adv();

    // Continuous contention: four D grants, then one forced I grant
    pat = 6'b101111;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) drive(1'b1, (k <= 4) ? 32'h40 : 32'h44, 1'b1, 1'b0,
                       32'h80 + 32'(4 * ((k < 4) ? k : 4)), '0, '0);
      else       drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      settle();
      if (k < 6) chk($sformatf("cont%0d_grant", k), 32'({i_req_ready, d_req_ready}),
                     32'({!pat[k], pat[k]}));
      if (k > 0) chk($sformatf("cont%0d_rsp", k), 32'({i_rsp_valid, d_rsp_valid}),
                     32'({!pat[k-1], pat[k-1]}));
      adv();
    end

    // Guard disabled instance never grants I under contention
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, last_gi ? 32'h48 + 32'(4 * k) : i_req_addr, 1'b1, 1'b0, 32'h100 + 32'(4 * k), '0, '0);
      settle();
      chk($sformatf("nolim%0d", k), 32'({z_i_req_ready, z_d_req_ready}), 32'b01);
      adv();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    adv();

    // Reset while a load is in flight
    drive(1'b0, '0, 1'b1, 1'b0, 32'h20, '0, '0);
    settle();
    chk("rmo_grant", 32'(d_req_ready), 32'd1);
    adv();
    rst = 1'b1;
    settle();
    chk("rmo_in_rst", 32'({d_rsp_valid, d_req_ready}), 32'd0);
    adv();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("rmo_after", 32'(d_rsp_valid), 32'd0);
    adv();
    drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("rmo_new_grant", 32'({i_req_ready, mem_ren}), 32'b11);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("rmo_new_rsp", i_rsp_data, 32'hC0DE_0004);
    adv();

    // Random traffic obeying the hold-until-ready rule
    for (int n = 0; n < 400; n++) begin
      if (!(i_req_valid && !last_gi)) begin
        i_req_valid = ($urandom_range(0, 3) != 0);
        i_req_addr  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
                      32'($urandom_range(0, 3));
      end
      if (!(d_req_valid && !last_gd)) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_req_wen   = $urandom_range(0, 1) == 1;
        d_req_addr  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
                      32'($urandom_range(0, 3));
        d_req_wdata = $urandom();
        d_req_mask  = 4'($urandom_range(0, 15));
      end
      settle();
      adv();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
